// File: rtl/wb_sdram_arb_if.sv
// Wishbone link bundle shared by the two masters and the SDRAM controller port.
// Masters connect through slave (arbiter side); the controller side uses ctrl.
interface wb_sdram_arb_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic [2:0]      cti;
  logic            ack;
  logic            err;
  logic [DW-1:0]   dat_r;

  modport master (output cyc, stb, we, addr, dat_w, sel, cti, input ack, err, dat_r);
  modport slave  (input cyc, stb, we, addr, dat_w, sel, cti, output ack, err, dat_r);
  // The SDRAM controller port carries no error line back to the arbiter.
  modport ctrl   (output cyc, stb, we, addr, dat_w, sel, cti, input ack, dat_r);
endinterface

// File: rtl/wb_sdram_arb.sv
// Two-master round-robin Wishbone arbiter in front of an SDRAM controller port,
// with a per-transfer ack timeout that aborts a stuck owner with a one-cycle err.
module wb_sdram_arb #(
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              wb_clk_i,
  input  logic              wb_resetn,
  input  logic              sdr_init_done,
  wb_sdram_arb_if.slave     m0,
  wb_sdram_arb_if.slave     m1,
  wb_sdram_arb_if.ctrl      s,
  output logic [1:0]        gnt_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX  = {TO_W{1'b1}};

  state_t          state_q, state_d;
  logic            own_q, own_d;
  logic            last_q, last_d;
  logic            rdy_q, rdy_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic req0, req1;
  logic in_busy;
  logic own_cyc;
  logic own_stb;

  assign req0    = m0.cyc & m0.stb;
  assign req1    = m1.cyc & m1.stb;
  assign in_busy = (state_q == BUSY);
  assign own_cyc = own_q ? m1.cyc : m0.cyc;
  assign own_stb = own_q ? m1.stb : m0.stb;

  // rdy_q holds off grants until the first edge after reset release.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    rdy_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (rdy_q && sdr_init_done && (req0 || req1)) begin
          state_d = BUSY;
          own_d   = (req0 && req1) ? ~last_q : req1;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = own_q;
        end else if ((cnt_q == CNT_LAST) && !s.ack) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = IDLE;
        last_d  = own_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ack-wait counter: runs only while a strobe is outstanding, sticks at all-ones.
  always_comb begin
    cnt_d = '0;
    if (in_busy && own_stb && !s.ack) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.addr  = '0;
    s.dat_w = '0;
    s.sel   = '0;
    s.cti   = '0;
    if (in_busy) begin
      if (own_q) begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.addr  = m1.addr;
        s.dat_w = m1.dat_w;
        s.sel   = m1.sel;
        s.cti   = m1.cti;
      end else begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.addr  = m0.addr;
        s.dat_w = m0.dat_w;
        s.sel   = m0.sel;
        s.cti   = m0.cti;
      end
    end
  end

  always_comb begin
    m0.ack   = in_busy & ~own_q & s.ack;
    m1.ack   = in_busy &  own_q & s.ack;
    m0.dat_r = (in_busy & ~own_q) ? s.dat_r : '0;
    m1.dat_r = (in_busy &  own_q) ? s.dat_r : '0;
    m0.err   = (state_q == ABORT) & ~own_q;
    m1.err   = (state_q == ABORT) &  own_q;
    gnt_o    = in_busy ? {own_q, ~own_q} : 2'b00;
    busy_o   = in_busy;
  end

endmodule
